// File: rtl/axis_packet_framer.sv
// axis_packet_framer: store-and-forward packet framer placed behind the 4:1 arbiter.
// Each complete input packet is buffered and then sent as one header word
// {SYNC, trunc, chan_err, channel, length} followed by its payload.
// Packets longer than MAX_LEN are cut to MAX_LEN beats; the extra beats are dropped.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   s_t_valid/ready/data/id/last       merged AXI-Stream input from the arbiter
//   s_idx_channel                      arbiter source channel, valid with s_t_valid
//   m_t_valid/ready/data/id/last       framed output stream (registered)
//   pkt_count                          count of fully sent frames, wraps at 16 bits
module axis_packet_framer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned MAX_LEN    = DEPTH,
    parameter int unsigned DESC_DEPTH = 4,
    parameter logic [7:0]  SYNC       = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_t_valid,
    output logic              s_t_ready,
    input  logic [DATA_W-1:0] s_t_data,
    input  logic [ID_W-1:0]   s_t_id,
    input  logic              s_t_last,
    input  logic [1:0]        s_idx_channel,
    output logic              m_t_valid,
    input  logic              m_t_ready,
    output logic [DATA_W-1:0] m_t_data,
    output logic [ID_W-1:0]   m_t_id,
    output logic              m_t_last,
    output logic [15:0]       pkt_count
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PTR_W  = AW + 1;
    localparam int unsigned DAW    = $clog2(DESC_DEPTH);
    localparam int unsigned DPTR_W = DAW + 1;
    localparam int unsigned LEN_W  = 16;

    typedef struct packed {
        logic [1:0]       chan;
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
        logic             trunc;
        logic             chan_err;
    } desc_t;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    // Storage: payload ring and descriptor ring, pointers carry one wrap bit.
    logic [DATA_W-1:0] mem [DEPTH];
    desc_t             desc_mem [DESC_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DPTR_W-1:0] desc_wr, desc_rd;

    // Input-side packet state.
    logic             in_pkt;
    logic [1:0]       cap_chan;
    logic [ID_W-1:0]  cap_id;
    logic [LEN_W-1:0] wr_cnt;
    logic             trunc_flag;
    logic             chan_err_flag;

    logic             data_full, desc_full, desc_empty;
    logic             at_max, in_fire, first_beat, push;
    logic [1:0]       beat_chan;
    logic [ID_W-1:0]  beat_id;
    logic             beat_mismatch, beat_trunc, beat_cerr;
    logic [LEN_W-1:0] beat_cnt;
    desc_t            push_desc;

    // Output-side state.
    state_t            state, state_nxt;
    logic              valid_nxt, last_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic [ID_W-1:0]   id_nxt;
    logic [LEN_W-1:0]  out_beat, out_beat_nxt;
    logic              rd_inc, pop;
    desc_t             head;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] hdr_word;

    // Input-side combinational view of the current beat.
    always_comb begin
        data_full     = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);
        desc_full     = (desc_wr - desc_rd) == DPTR_W'(DESC_DEPTH);
        desc_empty    = desc_wr == desc_rd;
        at_max        = wr_cnt == LEN_W'(MAX_LEN);
        // Once truncating, beats are dropped, so a full buffer must not stall them.
        s_t_ready     = !reset && !desc_full && (at_max || !data_full);
        in_fire       = s_t_valid && s_t_ready;
        first_beat    = !in_pkt;
        beat_chan     = first_beat ? s_idx_channel : cap_chan;
        beat_id       = first_beat ? s_t_id : cap_id;
        beat_mismatch = !first_beat && ((s_idx_channel != cap_chan) || (s_t_id != cap_id));
        beat_trunc    = (!first_beat && trunc_flag) || at_max;
        beat_cerr     = (!first_beat && chan_err_flag) || beat_mismatch;
        beat_cnt      = at_max ? wr_cnt : wr_cnt + LEN_W'(1);
        push          = in_fire && s_t_last;
        push_desc     = '{chan: beat_chan, id: beat_id, len: beat_cnt,
                          trunc: beat_trunc, chan_err: beat_cerr};
    end

    // Storage writes; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (in_fire && !at_max) begin
            mem[wr_ptr[AW-1:0]] <= s_t_data;
        end
        if (push) begin
            desc_mem[desc_wr[DAW-1:0]] <= push_desc;
        end
    end

    // Input packet tracking and descriptor push.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            desc_wr       <= '0;
            in_pkt        <= 1'b0;
            wr_cnt        <= '0;
            cap_chan      <= '0;
            cap_id        <= '0;
            trunc_flag    <= 1'b0;
            chan_err_flag <= 1'b0;
        end else if (in_fire) begin
            if (!at_max) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            cap_chan      <= beat_chan;
            cap_id        <= beat_id;
            trunc_flag    <= beat_trunc;
            chan_err_flag <= beat_cerr;
            if (s_t_last) begin
                desc_wr <= desc_wr + DPTR_W'(1);
                in_pkt  <= 1'b0;
                wr_cnt  <= '0;
            end else begin
                in_pkt  <= 1'b1;
                wr_cnt  <= beat_cnt;
            end
        end
    end

    // Output next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        valid_nxt     = m_t_valid;
        last_nxt      = m_t_last;
        data_nxt      = m_t_data;
        id_nxt        = m_t_id;
        out_beat_nxt  = out_beat;
        rd_inc        = 1'b0;
        pop           = 1'b0;
        head          = desc_mem[desc_rd[DAW-1:0]];
        rd_word       = mem[rd_ptr[AW-1:0]];
        hdr_word      = '0;
        hdr_word[31:0] = {SYNC, head.trunc, head.chan_err, 4'b0000, head.chan, head.len};

        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                if (!desc_empty) begin
                    valid_nxt = 1'b1;
                    data_nxt  = hdr_word;
                    id_nxt    = head.id;
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                if (m_t_ready) begin
                    data_nxt     = rd_word;
                    rd_inc       = 1'b1;
                    out_beat_nxt = LEN_W'(1);
                    last_nxt     = head.len == LEN_W'(1);
                    state_nxt    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (m_t_ready) begin
                    if (m_t_last) begin
                        pop       = 1'b1;
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        data_nxt     = rd_word;
                        rd_inc       = 1'b1;
                        out_beat_nxt = out_beat + LEN_W'(1);
                        last_nxt     = (out_beat + LEN_W'(1)) == head.len;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // Output state register and registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            m_t_valid <= 1'b0;
            m_t_last  <= 1'b0;
            m_t_data  <= '0;
            m_t_id    <= '0;
            out_beat  <= '0;
            rd_ptr    <= '0;
            desc_rd   <= '0;
            pkt_count <= '0;
        end else begin
            state     <= state_nxt;
            m_t_valid <= valid_nxt;
            m_t_last  <= last_nxt;
            m_t_data  <= data_nxt;
            m_t_id    <= id_nxt;
            out_beat  <= out_beat_nxt;
            if (rd_inc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (pop) begin
                desc_rd   <= desc_rd + DPTR_W'(1);
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_framer.sv
// Directed bench for axis_packet_framer (DEPTH = MAX_LEN = 16 so the
// truncation/buffer-full corner is reachable with short packets).
module tb_axis_packet_framer;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned MAX_LEN = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_t_valid;
    logic              s_t_ready;
    logic [DATA_W-1:0] s_t_data;
    logic [ID_W-1:0]   s_t_id;
    logic              s_t_last;
    logic [1:0]        s_idx_channel;
    logic              m_t_valid;
    logic              m_t_ready;
    logic [DATA_W-1:0] m_t_data;
    logic [ID_W-1:0]   m_t_id;
    logic              m_t_last;
    logic [15:0]       pkt_count;

    axis_packet_framer #(
        .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN),
        .DESC_DEPTH(4), .SYNC(8'hA5)
    ) dut (
        .clk(clk), .reset(reset),
        .s_t_valid(s_t_valid), .s_t_ready(s_t_ready), .s_t_data(s_t_data),
        .s_t_id(s_t_id), .s_t_last(s_t_last), .s_idx_channel(s_idx_channel),
        .m_t_valid(m_t_valid), .m_t_ready(m_t_ready), .m_t_data(m_t_data),
        .m_t_id(m_t_id), .m_t_last(m_t_last), .pkt_count(pkt_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } in_beat_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } out_beat_t;

    in_beat_t  vin[$];
    out_beat_t vexp[$];
    out_beat_t out_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stalls   = 0;
    int last_acc_cyc    = 0;
    int first_valid_cyc = -1;

    logic [31:0] hold_data;
    logic [3:0]  hold_id;
    bit          hold_armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: records handshakes and checks hold-while-stalled.
    always @(negedge clk) begin
        if (reset) begin
            hold_armed = 1'b0;
        end else begin
            if (hold_armed) begin
                check("hold_valid", 32'(m_t_valid), 32'd1);
                check("hold_data", m_t_data, hold_data);
                check("hold_id", 32'(m_t_id), 32'(hold_id));
            end
            if (m_t_valid && m_t_ready) out_q.push_back('{m_t_data, m_t_id, m_t_last});
            if (m_t_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            hold_armed = m_t_valid && !m_t_ready;
            hold_data  = m_t_data;
            hold_id    = m_t_id;
        end
    end

    task automatic send_beat(input logic [1:0] ch, input logic [3:0] id,
                             input logic [31:0] d, input logic l);
        int waited = 0;
        s_t_valid = 1'b1; s_idx_channel = ch; s_t_id = id; s_t_data = d; s_t_last = l;
        @(negedge clk);
        while (!s_t_ready && waited < 1000) begin
            waited++;
            @(negedge clk);
        end
        if (!s_t_ready) timeout_fail("input_accept");
        @(posedge clk); #1;
        if (waited > 0) stalls++;
        last_acc_cyc = cyc;
    endtask

    task automatic apply_reset();
        reset = 1'b1; s_t_valid = 1'b0; s_t_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic compare_out(input string name);
        int t = 0;
        while (out_q.size() < vexp.size() && t < 2000) begin
            @(posedge clk); t++;
        end
        #1;
        if (out_q.size() < vexp.size()) timeout_fail({name, "_frames"});
        repeat (4) @(posedge clk); #1;
        check({name, "_beat_count"}, 32'(out_q.size()), 32'(vexp.size()));
        for (int i = 0; i < vexp.size() && i < out_q.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), out_q[i].data, vexp[i].data);
            check($sformatf("%s_id%0d", name, i), 32'(out_q[i].id), 32'(vexp[i].id));
            check($sformatf("%s_last%0d", name, i), 32'(out_q[i].last), 32'(vexp[i].last));
        end
    endtask

    // Apply vin, compare against vexp, check header latency and frame count.
    task automatic run_table(input bit do_reset, input string name);
        int first_last = -1;
        int frames = 0;
        if (do_reset) apply_reset();
        out_q.delete();
        first_valid_cyc = -1;
        stalls = 0;
        for (int i = 0; i < vin.size(); i++) begin
            send_beat(vin[i].ch, vin[i].id, vin[i].data, vin[i].last);
            if (vin[i].last) begin
                frames++;
                if (first_last < 0) first_last = last_acc_cyc;
            end
        end
        s_t_valid = 1'b0; s_t_last = 1'b0;
        compare_out(name);
        // Header valid two cycles after the last beat: one edge after the accept edge.
        check({name, "_hdr_latency"}, 32'(first_valid_cyc), 32'(first_last + 1));
        repeat (3) @(posedge clk); #1;
        check({name, "_pkt_count"}, 32'(pkt_count), 32'(frames));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int ready_seen;
        reset = 1'b1; s_t_valid = 1'b0; s_t_data = '0; s_t_id = '0; s_t_last = 1'b0;
        s_idx_channel = '0; m_t_ready = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_s_t_ready", 32'(s_t_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_m_t_valid", 32'(m_t_valid), 32'd0);
        check("rst_m_t_last", 32'(m_t_last), 32'd0);
        check("rst_m_t_data", m_t_data, 32'd0);
        check("rst_m_t_id", 32'(m_t_id), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);

        // Single 3-beat packet on channel 2.
        vin.delete(); vexp.delete();
        vin.push_back('{2'd2, 4'd5, 32'h11, 1'b0});
        vin.push_back('{2'd2, 4'd5, 32'h22, 1'b0});
        vin.push_back('{2'd2, 4'd5, 32'h33, 1'b1});
        vexp.push_back('{32'hA502_0003, 4'd5, 1'b0});
        vexp.push_back('{32'h11, 4'd5, 1'b0});
        vexp.push_back('{32'h22, 4'd5, 1'b0});
        vexp.push_back('{32'h33, 4'd5, 1'b1});
        run_table(1'b1, "t1");

        // Back-to-back packets, channels 0..3, lengths 1..4.
        vin.delete(); vexp.delete();
        for (int p = 0; p < 4; p++) begin
            vexp.push_back('{{8'hA5, 8'(p), 16'(p + 1)}, 4'(p), 1'b0});
            for (int b = 0; b <= p; b++) begin
                vin.push_back('{2'(p), 4'(p), 32'((p + 1) * 256 + b), (b == p)});
                vexp.push_back('{32'((p + 1) * 256 + b), 4'(p), (b == p)});
            end
        end
        run_table(1'b1, "t2");

        // 20-beat packet truncated to 16 with the buffer full; input never stalls.
        vin.delete(); vexp.delete();
        vexp.push_back('{32'hA581_0010, 4'd3, 1'b0});
        for (int b = 0; b < 20; b++) begin
            vin.push_back('{2'd1, 4'd3, 32'(b + 1), (b == 19)});
            if (b < 16) vexp.push_back('{32'(b + 1), 4'd3, (b == 15)});
        end
        run_table(1'b1, "t3");
        check("t3_no_input_stall", 32'(stalls), 32'd0);

        // Output stalled: descriptor FIFO fills after 4 packets.
        apply_reset();
        out_q.delete(); vexp.delete(); stalls = 0;
        m_t_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(2'(i), 4'(i), 32'(32'h50 + i), 1'b1);
        check("t4_first4_no_stall", 32'(stalls), 32'd0);
        s_t_valid = 1'b1; s_idx_channel = 2'd0; s_t_id = 4'd4; s_t_data = 32'h54; s_t_last = 1'b1;
        ready_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (s_t_ready) ready_seen++;
        end
        @(posedge clk); #1;
        check("t4_ready_low_when_desc_full", 32'(ready_seen), 32'd0);
        check("t4_hdr_held_valid", 32'(m_t_valid), 32'd1);
        check("t4_hdr_held_data", m_t_data, 32'hA500_0001);
        check("t4_hdr_held_id", 32'(m_t_id), 32'd0);
        m_t_ready = 1'b1;
        send_beat(2'd0, 4'd4, 32'h54, 1'b1);
        s_t_valid = 1'b0; s_t_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vexp.push_back('{{8'hA5, 6'd0, 2'(i % 4), 16'd1}, 4'(i), 1'b0});
            vexp.push_back('{32'(32'h50 + i), 4'(i), 1'b1});
        end
        compare_out("t4");
        check("t4_pkt_count", 32'(pkt_count), 32'd5);

        // Channel changes mid-packet: chan_err set, payload intact.
        vin.delete(); vexp.delete();
        vin.push_back('{2'd1, 4'd7, 32'h0A, 1'b0});
        vin.push_back('{2'd1, 4'd7, 32'h0B, 1'b0});
        vin.push_back('{2'd3, 4'd7, 32'h0C, 1'b1});
        vexp.push_back('{32'hA541_0003, 4'd7, 1'b0});
        vexp.push_back('{32'h0A, 4'd7, 1'b0});
        vexp.push_back('{32'h0B, 4'd7, 1'b0});
        vexp.push_back('{32'h0C, 4'd7, 1'b1});
        run_table(1'b1, "t5");

        // Reset in the middle of a packet discards it.
        out_q.delete();
        send_beat(2'd0, 4'd2, 32'h61, 1'b0);
        send_beat(2'd0, 4'd2, 32'h62, 1'b0);
        s_t_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("t6_partial_not_sent", 32'(out_q.size()), 32'd0);
        check("t6_partial_no_valid", 32'(m_t_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("t6_ready_in_reset", 32'(s_t_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_m_t_valid", 32'(m_t_valid), 32'd0);
        check("t6_m_t_last", 32'(m_t_last), 32'd0);
        check("t6_m_t_data", m_t_data, 32'd0);
        check("t6_m_t_id", 32'(m_t_id), 32'd0);
        check("t6_pkt_count", 32'(pkt_count), 32'd0);
        vin.delete(); vexp.delete();
        vin.push_back('{2'd2, 4'd9, 32'h71, 1'b0});
        vin.push_back('{2'd2, 4'd9, 32'h72, 1'b1});
        vexp.push_back('{32'hA502_0002, 4'd9, 1'b0});
        vexp.push_back('{32'h71, 4'd9, 1'b0});
        vexp.push_back('{32'h72, 4'd9, 1'b1});
        run_table(1'b0, "t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_packet_framer.md
Name: axis_packet_framer

Overview:
- Sits directly downstream of the 4-to-1 round-robin arbiter.
- Consumes the merged AXI-Stream output and the arbiter's idx_channel sideband.
- Store-and-forward: buffers each complete packet, then emits a header word carrying source channel, length and error flags, followed by the payload, to the serial link stage.
- Enforces a maximum packet length by truncating oversize packets.

Parameters:
- DATA_W, 32: stream data width; must be >= 32.
- ID_W, 4: t_id width.
- DEPTH, 256: payload buffer depth in words; power of two.
- MAX_LEN, DEPTH: maximum payload beats per packet; must be <= DEPTH and <= 65535.
- DESC_DEPTH, 4: descriptor FIFO depth (completed packets awaiting output); power of two.
- SYNC, 8'hA5: header sync byte.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_t_valid  in  1  input beat valid (from arbiter out).
- s_t_ready  out  1  input beat ready.
- s_t_data  in  DATA_W  input data.
- s_t_id  in  ID_W  input id.
- s_t_last  in  1  last beat of packet.
- s_idx_channel  in  2  arbiter source channel, valid with s_t_valid.
- m_t_valid  out  1  output beat valid.
- m_t_ready  in  1  output beat ready.
- m_t_data  out  DATA_W  header or payload.
- m_t_id  out  ID_W  packet id, on every beat including header.
- m_t_last  out  1  last payload beat.
- pkt_count  out  16  frames fully sent; wraps at 0xFFFF->0.

Behaviour:
- Reset: s_t_ready=0 in the reset cycle. m_t_valid=0, m_t_last=0, m_t_data=0, m_t_id=0, pkt_count=0. Both FIFOs are emptied, any partial input packet is discarded, and the FSM goes to IDLE. Reset mid-packet has the same effect; the next s_t_valid beat is treated as a first beat.
- Input handshake: a beat transfers when s_t_valid & s_t_ready.
  - s_t_ready = !reset & !desc_full & (trunc | !data_full).
  - trunc = the current packet's write count has reached MAX_LEN.
- Input, first beat of a packet: capture s_idx_channel and s_t_id; clear flags.
- Input, each accepted beat:
  - If count < MAX_LEN, write data to the buffer and increment count.
  - Otherwise discard the beat and set the trunc flag.
  - If s_idx_channel or s_t_id differs from the captured value, set the chan_err flag.
- Input, beat with s_t_last: push descriptor {channel, id, count, trunc, chan_err} on the same edge, and reset the count to 0.
- Packet length is always >= 1.
- Simultaneous descriptor push and pop in one cycle is legal; occupancy is unchanged.
- Header word layout:
  - [31:24]=SYNC
  - [23]=trunc
  - [22]=chan_err
  - [21:18]=0
  - [17:16]=channel
  - [15:0]=payload length (beats actually emitted)
  - bits [DATA_W-1:32]=0
- Output FSM (outputs registered):
  - IDLE: m_t_valid=0. If the descriptor FIFO is non-empty, load the header into the output register and go to HEADER.
  - HEADER: m_t_valid=1, m_t_last=0. On handshake, present the first payload word and go to PAYLOAD.
  - PAYLOAD: one buffer word per handshake. m_t_last=1 on beat number = length. On the last handshake, pop the descriptor, increment pkt_count, and go to IDLE (one idle cycle between frames).
- Output data rules:
  - m_t_data and m_t_id hold stable while m_t_valid & !m_t_ready.
  - m_t_valid never drops without a handshake.
- Latency: with the output idle, a last beat accepted in cycle T gives header m_t_valid=1 in cycle T+2.
- Boundaries:
  - Buffer full mid-packet: s_t_ready=0 until the output frees space.
  - Buffer full at MAX_LEN=DEPTH: the trunc path keeps s_t_ready=1 until s_t_last (no deadlock).
  - Descriptor FIFO full: s_t_ready=0 for all beats.
  - Pointers wrap modulo DEPTH.
  - Output only starts on completed packets; partial packets are never emitted.

Test Plan:
1. Single packet ch2, id 5, data 0x11,0x22,0x33, m_t_ready=1 -> header 0xA5020003 id 5 at T+2, then 0x11,0x22,0x33 with m_t_last on 0x33; pkt_count=1.
2. Back-to-back packets ch0..3, lengths 1,2,3,4, continuous valid -> 4 frames in order, 14 output beats total, channels 0,1,2,3 in headers; pkt_count=4.
3. DEPTH=MAX_LEN=16, 20-beat packet ch1 -> s_t_ready stays 1 through beat 20; header 0xA5810010; first 16 data words out, m_t_last on the 16th.
4. m_t_ready=0 for 50 cycles, 5 single-beat packets -> s_t_ready=0 after the 4th descriptor; after release, all 5 frames out in order, pkt_count=5, no data loss.
5. 3-beat packet with s_idx_channel 1,1,3 -> header bit 22 set (0xA5410003), payload intact.
6. Reset asserted after beat 2 of a 4-beat packet -> next cycle all outputs 0, pkt_count=0; no frame emitted for the partial packet; the following 2-beat packet is framed as 0xA50x0002.
